mem_xfer_engine: RTL and testbench

MEM_XFER_ENGINE -- requirements
Module: mem_xfer_engine

---
 rtl/mem_xfer_pkg.sv | 13 +
 rtl/xfer_sync_fifo.sv | 65 ++++++
 rtl/mem_xfer_engine.sv | 136 +++++++++++++
 tb/tb_mem_xfer_engine.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_xfer_pkg.sv
// Shared types and constants for the memory transfer engine.
package mem_xfer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } xfer_state_e;

    localparam logic MODE_COPY    = 1'b0;
    localparam logic MODE_REVERSE = 1'b1;

endpackage

// File: rtl/xfer_sync_fifo.sv
// Single-clock show-ahead FIFO; clr empties it without touching storage.
module xfer_sync_fifo #(
    parameter  int WIDTH      = 8,
    parameter  int FIFO_DEPTH = 4,
    localparam int PW         = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (PW+1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Pointer/count next state; overflow and underflow requests are dropped.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are never reset.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mem_xfer_engine.sv
// Loads a source memory, then copies it (in order or reversed) through a
// small FIFO into a destination memory that is read out through a register.
module mem_xfer_engine
    import mem_xfer_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int DEPTH      = 16,
    parameter  int FIFO_DEPTH = 4,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] port_A,
    input  logic             W_en,
    input  logic             s_sig,
    input  logic             mode,
    input  logic             R_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] port_D,
    output logic             busy,
    output logic             done,
    output logic [AW:0]      xfer_count
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [AW:0]  DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]  LAST_C   = (AW+1)'(DEPTH - 1);
    localparam logic [FCW-1:0] FONE_C = FCW'(1);

    logic [WIDTH-1:0] src_mem [DEPTH];
    logic [WIDTH-1:0] dst_mem [DEPTH];

    xfer_state_e      state_q, state_d;
    logic [AW-1:0]    load_ptr_q, load_ptr_d;
    logic [AW:0]      push_cnt_q, push_cnt_d;
    logic [AW:0]      xfer_count_q, xfer_count_d;
    logic             mode_q, mode_d;
    logic             s_prev_q;
    logic [WIDTH-1:0] port_d_q, port_d_d;

    logic             start, push, pop, fifo_clr, src_we;
    logic [AW-1:0]    src_idx;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_full, fifo_empty;
    logic [FCW-1:0]   fifo_count;

    // With DEPTH a power of two, DEPTH-1-k is just the bitwise inverse of k.
    assign src_idx = push_cnt_q[AW-1:0] ^ {AW{mode_q == MODE_REVERSE}};

    xfer_sync_fifo #(.WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr),
        .push  (push),
        .din   (src_mem[src_idx]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // FSM next state, load pointer, push/pop control and read-port mux.
    always_comb begin
        state_d      = state_q;
        load_ptr_d   = load_ptr_q;
        push_cnt_d   = push_cnt_q;
        xfer_count_d = xfer_count_q;
        mode_d       = mode_q;
        fifo_clr     = 1'b0;
        src_we       = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        start        = (state_q == ST_IDLE) && s_sig && !s_prev_q;
        case (state_q)
            ST_IDLE: begin
                src_we = W_en;
                if (W_en) load_ptr_d = load_ptr_q + AW'(1);
                if (start) begin
                    state_d      = ST_RUN;
                    mode_d       = mode;
                    push_cnt_d   = '0;
                    xfer_count_d = '0;
                    fifo_clr     = 1'b1;
                end
            end
            ST_RUN: begin
                push = !fifo_full && (push_cnt_q < DEPTH_C);
                pop  = !fifo_empty;
                if (push) push_cnt_d = push_cnt_q + (AW+1)'(1);
                if (pop) begin
                    xfer_count_d = xfer_count_q + (AW+1)'(1);
                    // Last word leaving with nothing queued behind it.
                    if (xfer_count_q == LAST_C && fifo_count == FONE_C)
                        state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        port_d_d = R_en ? dst_mem[rd_addr] : port_d_q;
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            load_ptr_q   <= '0;
            push_cnt_q   <= '0;
            xfer_count_q <= '0;
            mode_q       <= MODE_COPY;
            s_prev_q     <= 1'b0;
            port_d_q     <= '0;
        end else begin
            state_q      <= state_d;
            load_ptr_q   <= load_ptr_d;
            push_cnt_q   <= push_cnt_d;
            xfer_count_q <= xfer_count_d;
            mode_q       <= mode_d;
            s_prev_q     <= s_sig;
            port_d_q     <= port_d_d;
        end
    end

    // Memory writes; contents survive reset, but reset blocks new writes.
    always_ff @(posedge clk) begin
        if (src_we && !rst) src_mem[load_ptr_q] <= port_A;
        if (pop && !rst)    dst_mem[xfer_count_q[AW-1:0]] <= fifo_dout;
    end

    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign xfer_count = xfer_count_q;
    assign port_D     = port_d_q;

endmodule

// File: tb/tb_mem_xfer_engine.sv
// Bench for mem_xfer_engine: transfer-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_xfer_engine;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst, W_en, s_sig, mode, R_en;
    logic [WIDTH-1:0] port_A;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] port_D;
    logic             busy, done;
    logic [AW:0]      xfer_count;

    mem_xfer_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .port_A(port_A), .W_en(W_en), .s_sig(s_sig),
        .mode(mode), .R_en(R_en), .rd_addr(rd_addr), .port_D(port_D),
        .busy(busy), .done(done), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transfer is a phase count 1..DEPTH+1 (busy), then
    // DEPTH+2 (done). Word j lands in dst during phase j+2.
    logic [WIDTH-1:0] m_src [DEPTH];
    logic [WIDTH-1:0] m_dst [DEPTH];
    logic [WIDTH-1:0] m_pd;
    int  m_phase, m_lptr, m_xcnt;
    bit  m_prev, m_mode;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_xcnt = 0; m_pd = '0; m_lptr = 0; m_prev = 0;
        end else begin
            if (R_en) m_pd = m_dst[rd_addr];
            if (m_phase == 0) begin
                if (W_en) begin
                    m_src[m_lptr] = port_A;
                    m_lptr = (m_lptr + 1) % DEPTH;
                end
                if (s_sig && !m_prev) begin
                    m_phase = 1; m_mode = mode; m_xcnt = 0;
                end
            end else if (m_phase <= DEPTH + 1) begin
                if (m_phase >= 2) begin
                    int j;
                    j = m_phase - 2;
                    m_dst[j] = m_src[m_mode ? DEPTH - 1 - j : j];
                    m_xcnt = j + 1;
                end
                m_phase++;
            end else begin
                m_phase = 0;
            end
            m_prev = s_sig;
        end
        #1;
        check("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= DEPTH + 1));
        check("done", 32'(done), 32'(m_phase == DEPTH + 2));
        check("xfer_count", 32'(xfer_count), 32'(m_xcnt));
        check("port_D", 32'(port_D), 32'(m_pd));
    end

    logic [WIDTH-1:0] load_data [DEPTH] = '{8'd4, 8'd14, 8'd24, 8'd42, 8'd141, 8'd243, 8'd41, 8'd134,
                                            8'd204, 8'd124, 8'd104, 8'd24, 8'd34, 8'd74, 8'd84, 8'd95};

    task automatic pulse_start(input logic m);
        @(negedge clk); s_sig = 1'b1; mode = m;
        @(negedge clk); s_sig = 1'b0;
    endtask

    // Samples the current cycle first, then advances; returns busy/done totals.
    task automatic count_cycles(input int n, output int bc, output int dc);
        bc = 0; dc = 0;
        for (int i = 0; i < n; i++) begin
            bc += int'(busy); dc += int'(done);
            @(negedge clk);
        end
    endtask

    task automatic read_chk(input logic [AW-1:0] a, input logic [WIDTH-1:0] exp, input string name);
        @(negedge clk); R_en = 1'b1; rd_addr = a;
        @(negedge clk); R_en = 1'b0;
        check(name, 32'(port_D), 32'(exp));
    endtask

    initial begin
        int bc, dc;
        rst = 1'b1; W_en = 1'b0; s_sig = 1'b0; mode = 1'b0; R_en = 1'b0;
        port_A = '0; rd_addr = '0;
        @(negedge clk); @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_port_D", 32'(port_D), 32'd0);
        check("reset_xfer_count", 32'(xfer_count), 32'd0);
        rst = 1'b0;

        // Load source memory.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk); W_en = 1'b1; port_A = load_data[i];
        end
        @(negedge clk); W_en = 1'b0;

        // In-order copy.
        pulse_start(1'b0);
        count_cycles(25, bc, dc);
        check("copy_busy_cycles", 32'(bc), 32'd17);
        check("copy_done_pulses", 32'(dc), 32'd1);
        check("copy_xfer_count", 32'(xfer_count), 32'd16);
        read_chk(4'd0, 8'd4, "copy_dst0");
        read_chk(4'd15, 8'd95, "copy_dst15");
        read_chk(4'd3, 8'd42, "copy_dst3");
        @(negedge clk);
        check("read_hold", 32'(port_D), 32'd42);

        // Reversed copy.
        pulse_start(1'b1);
        count_cycles(25, bc, dc);
        check("rev_done_pulses", 32'(dc), 32'd1);
        read_chk(4'd0, 8'd95, "rev_dst0");
        read_chk(4'd15, 8'd4, "rev_dst15");

        // Start held high: one transfer only.
        @(negedge clk); s_sig = 1'b1; mode = 1'b0;
        count_cycles(30, bc, dc);
        check("hold_done_pulses", 32'(dc), 32'd1);
        s_sig = 1'b0;

        // Loads and start edges during RUN are ignored.
        pulse_start(1'b0);
        bc = 0; dc = 0;
        for (int i = 0; i < 40; i++) begin
            W_en = (i == 2 || i == 3); port_A = 8'hFF;
            s_sig = (i == 3 || i == 5);
            bc += int'(busy); dc += int'(done);
            @(negedge clk);
        end
        W_en = 1'b0; s_sig = 1'b0;
        check("ign_busy_cycles", 32'(bc), 32'd17);
        check("ign_done_pulses", 32'(dc), 32'd1);
        pulse_start(1'b0);
        count_cycles(25, bc, dc);
        read_chk(4'd0, 8'd4, "ign_src0_intact");

        // Reset on the fifth busy cycle.
        pulse_start(1'b0);
        bc = 0;
        for (int i = 0; i < 40 && bc < 5; i++) begin
            bc += int'(busy);
            if (bc < 5) @(negedge clk);
        end
        check("rst_reached_busy5", 32'(bc), 32'd5);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_port_D", 32'(port_D), 32'd0);
        check("rst_xfer_count", 32'(xfer_count), 32'd0);
        pulse_start(1'b0);
        count_cycles(25, bc, dc);
        check("rerun_done_pulses", 32'(dc), 32'd1);
        check("rerun_xfer_count", 32'(xfer_count), 32'd16);
        read_chk(4'd15, 8'd95, "rerun_dst15");

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 149) == 0);
            W_en    = $urandom_range(0, 1) == 1;
            port_A  = WIDTH'($urandom);
            s_sig   = ($urandom_range(0, 5) == 0);
            mode    = $urandom_range(0, 1) == 1;
            R_en    = $urandom_range(0, 1) == 1;
            rd_addr = AW'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; W_en = 1'b0; s_sig = 1'b0; R_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
